rx_frame_parser: RTL and testbench

Byte-level frame parser that sits directly downstream of the UART receive module. It drives the receiver's `rx_en_sig`, consumes each `rx_done`/`rx_data` byte, and assembles frames of the form SYNC, LEN, payload, CSUM. Complete, checksum-verified payloads are held in a small buffer for the application to read, and the receiver is paused until the application acknowledges.

---
 rtl/rx_frame_pkg.sv | 19 +
 rtl/rx_frame_buf.sv | 33 +++
 rtl/rx_frame_parser.sv | 121 ++++++++++++
 tb/tb_rx_frame_parser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared definitions for the UART frame parser: state encoding, error codes
// and the default frame start marker.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

endpackage

// File: rtl/rx_frame_buf.sv
// Payload buffer: MAX_LEN bytes, one synchronous write port and one
// combinational read port.
module rx_frame_buf #(
    parameter int MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data
);

    localparam int         AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [4:0] DEPTH = 5'(MAX_LEN);

    logic [7:0] mem_q [MAX_LEN];
    logic       wr_ok;
    logic       rd_ok;

    assign wr_ok = ({1'b0, waddr} < DEPTH);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH);

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem_q[waddr[AW-1:0]] <= wdata;
        end
    end

    // Addresses past the array read as zero; callers treat them as don't-care.
    assign rd_data = rd_ok ? mem_q[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/rx_frame_parser.sv
// Frame parser behind the UART receiver: hunts SYNC, checks LEN and CSUM,
// holds a verified payload and pauses the receiver until acknowledged.
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter int         MAX_LEN   = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       rx_en_sig,
    output logic       frm_ready,
    output logic [3:0] frm_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       frm_ack,
    output logic       frm_err,
    output logic [1:0] frm_err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q;
    logic       rx_en_q;
    logic       ready_q;
    logic       err_q;
    logic [1:0] code_q;
    logic [3:0] len_q;
    logic [3:0] idx_q;
    logic [7:0] sum_q;
    logic       accept;
    logic       buf_we;

    assign accept = rx_done && rx_en_q;
    assign buf_we = accept && (state_q == ST_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            rx_en_q <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            len_q   <= 4'd0;
            idx_q   <= 4'd0;
            sum_q   <= 8'd0;
        end else begin
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            if (state_q == ST_HOLD) begin
                rx_en_q <= frm_ack;
                if (frm_ack) begin
                    state_q <= ST_HUNT;
                    ready_q <= 1'b0;
                end
            end else if (!accept) begin
                rx_en_q <= 1'b1;
            end else begin
                // Every accepted byte opens a one-cycle re-arm gap.
                rx_en_q <= 1'b0;
                case (state_q)
                    ST_HUNT: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_LEN;
                            state_q <= ST_HUNT;
                        end else begin
                            len_q   <= rx_data[3:0];
                            sum_q   <= rx_data;
                            idx_q   <= 4'd0;
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + 4'd1;
                        if (idx_q == len_q - 4'd1) begin
                            state_q <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_data == sum_q) begin
                            state_q <= ST_HOLD;
                            ready_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                            code_q  <= ERR_CSUM;
                            state_q <= ST_HUNT;
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    rx_frame_buf #(
        .MAX_LEN(MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .we      (buf_we),
        .waddr   (idx_q),
        .wdata   (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rx_en_sig    = rx_en_q;
    assign frm_ready    = ready_q;
    assign frm_err      = err_q;
    assign frm_err_code = code_q;
    assign frm_len      = len_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Randomized bench for rx_frame_parser against a queue-based frame model.
module tb_rx_frame_parser;

    localparam int         MAX_LEN = 8;
    localparam logic [7:0] SYNC    = 8'hAA;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_en_sig;
    logic       frm_ready;
    logic [3:0] frm_len;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frm_ack = 1'b0;
    logic       frm_err;
    logic [1:0] frm_err_code;

    int total = 0;
    int bad   = 0;

    // Model: bytes of the frame in progress, the last verified payload.
    logic [7:0] cur[$];
    logic [7:0] pay[$];
    bit         hold;
    bit         exp_err;
    int         exp_code;

    rx_frame_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_done      (rx_done),
        .rx_data      (rx_data),
        .rx_en_sig    (rx_en_sig),
        .frm_ready    (frm_ready),
        .frm_len      (frm_len),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frm_ack      (frm_ack),
        .frm_err      (frm_err),
        .frm_err_code (frm_err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [7:0] s;
        n = cur.size();
        exp_err  = 0;
        exp_code = 0;
        if (n == 0) begin
            if (b == SYNC) cur.push_back(b);
        end else if (n == 1) begin
            if (b == 0 || b > MAX_LEN) begin
                exp_err = 1; exp_code = 1; cur.delete();
            end else begin
                cur.push_back(b);
            end
        end else if (n < int'(cur[1]) + 2) begin
            cur.push_back(b);
        end else begin
            s = 8'h00;
            for (int i = 1; i < n; i++) s = s + cur[i];
            if (b == s) begin
                hold = 1;
                pay.delete();
                for (int i = 2; i < n; i++) pay.push_back(cur[i]);
            end else begin
                exp_err = 1; exp_code = 2;
            end
            cur.delete();
        end
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < pay.size(); i++) begin
            rd_addr = 4'(i);
            #1;
            chk(tag, rd_data, pay[i]);
        end
    endtask

    task automatic hold_phase();
        chk("hold_ready", frm_ready, 1);
        chk("hold_len", frm_len, pay.size());
        check_buf("rd_data");
        rd_addr = 4'(MAX_LEN + $urandom_range(0, 15 - MAX_LEN));
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rx_done = 1'b1;
            rx_data = 8'($urandom);
            @(posedge clk); #1;
            rx_done = 1'b0;
            chk("hold_en_low", rx_en_sig, 0);
        end
        chk("hold_ready_kept", frm_ready, 1);
        check_buf("rd_data_kept");
        @(negedge clk);
        frm_ack = 1'b1;
        rx_done = 1'b1;
        rx_data = SYNC;
        @(posedge clk); #1;
        frm_ack = 1'b0;
        rx_done = 1'b0;
        hold = 0;
        chk("ack_ready", frm_ready, 0);
        chk("ack_en", rx_en_sig, 1);
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!rx_en_sig && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rx_en_sig) begin
            chk("en_timeout", 0, 1);
            return;
        end
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        model_byte(b);
        chk("err", frm_err, int'(exp_err));
        if (exp_err) chk("err_code", frm_err_code, exp_code);
        chk("ready", frm_ready, int'(hold));
        chk("gap", rx_en_sig, 0);
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
            rx_done = 1'b1;
            rx_data = ($urandom_range(0, 1) == 1) ? SYNC : 8'($urandom);
            frm_ack = !hold && ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
        rx_done = 1'b0;
        frm_ack = 1'b0;
        chk("rearm", rx_en_sig, int'(!hold));
        chk("err_one_cycle", frm_err, 0);
        if (hold) hold_phase();
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"}, rx_en_sig, 0);
        chk({tag, "_ready"}, frm_ready, 0);
        chk({tag, "_err"}, frm_err, 0);
        chk({tag, "_code"}, frm_err_code, 0);
        chk({tag, "_len"}, frm_len, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_en", rx_en_sig, 1);

        send_q('{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
        send_q('{8'hAA, 8'h02, 8'h01, 8'h02, 8'h00});
        send_q('{8'hAA, 8'h01, 8'h7F, 8'h80});
        send_q('{8'hAA, 8'h00, 8'hAA, 8'h09});
        send_q('{8'h00, 8'h55, 8'hFF, 8'hAA, 8'h01, 8'hAA, 8'hAB});

        send_q('{8'hAA, 8'h04, 8'h01});
        #2 rst = 1'b1;
        #1;
        check_reset("mid_rst");
        cur.delete();
        hold = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_release_en", rx_en_sig, 1);
        send_q('{8'hAA, 8'h01, 8'h05, 8'h06});

        for (int f = 0; f < 40; f++) begin
            q.delete();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                s = 8'($urandom);
                q.push_back(s == SYNC ? 8'h00 : s);
            end
            q.push_back(SYNC);
            case ($urandom_range(0, 3))
                2: q.push_back(($urandom_range(0, 1) == 1) ? 8'h00
                               : 8'($urandom_range(MAX_LEN + 1, 255)));
                default: begin
                    n = $urandom_range(1, MAX_LEN);
                    q.push_back(8'(n));
                    s = 8'(n);
                    for (int k = 0; k < n; k++) begin
                        q.push_back(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom));
                        s = s + q[q.size() - 1];
                    end
                    if ($urandom_range(0, 3) == 1) s = s + 8'($urandom_range(1, 255));
                    q.push_back(s);
                end
            endcase
            send_q(q);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
